// File: rtl/ram_multiport_clr.sv
// Multi-port RAM: R registered read ports, one write port, write-first bypass,
// address range checking and a sequential clear engine that zeroes the array.
module ram_multiport_clr #(
    parameter int unsigned N = 16,    // data width
    parameter int unsigned M = 6000,  // depth in words
    parameter int unsigned K = 13,    // address width, 2^K >= M
    parameter int unsigned R = 2      // number of read ports
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             WE,
    input  logic [K-1:0]     addressWritePort,
    input  logic [N-1:0]     writePortData,
    input  logic [R*K-1:0]   readAddresses,
    output logic [R*N-1:0]   readDatas,
    input  logic             clearReq,
    output logic             busy,
    output logic             addrError
);

    typedef enum logic {StIdle, StClear} stateT;

    // K+1 bits so a depth of exactly 2^K still fits
    localparam logic [K:0]   Depth    = (K+1)'(M);
    localparam logic [K-1:0] LastAddr = K'(M - 1);

    logic [N-1:0] mem [0:M-1];

    stateT        stateQ, stateD;
    logic [K-1:0] clearPtrQ, clearPtrD;

    logic [K-1:0] rAddr [R];
    logic [R-1:0] rInRange;
    logic         wInRange;
    logic         writeOk;
    logic [R*N-1:0] readNext;
    logic         errNext;

    assign busy = (stateQ == StClear);

    // Unpack read addresses and classify every access against the depth
    always_comb begin
        wInRange = ({1'b0, addressWritePort} < Depth);
        rInRange = '0;
        for (int unsigned r = 0; r < R; r++) begin
            rAddr[r]    = readAddresses[r*K +: K];
            rInRange[r] = ({1'b0, rAddr[r]} < Depth);
        end
        // A simultaneous clear request takes priority over the write
        writeOk = (stateQ == StIdle) && WE && wInRange && !clearReq;
    end

    // Clear engine next-state: sweep 0..M-1 once, then idle until requested
    always_comb begin
        stateD    = stateQ;
        clearPtrD = clearPtrQ;
        unique case (stateQ)
            StClear: begin
                clearPtrD = clearPtrQ + K'(1);
                if (clearPtrQ == LastAddr) begin
                    stateD    = StIdle;
                    clearPtrD = '0;
                end
            end
            StIdle: begin
                if (clearReq) begin
                    stateD    = StClear;
                    clearPtrD = '0;
                end
            end
            default: begin
                stateD    = StClear;
                clearPtrD = '0;
            end
        endcase
    end

    // State register; reset always launches a fresh clear from address 0
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            stateQ    <= StClear;
            clearPtrQ <= '0;
        end else begin
            stateQ    <= stateD;
            clearPtrQ <= clearPtrD;
        end
    end

    // Single write port into the array, shared by the clear engine and user writes
    always_ff @(posedge Clk) begin
        if (stateQ == StClear) begin
            mem[clearPtrQ] <= '0;
        end else if (writeOk) begin
            mem[addressWritePort] <= writePortData;
        end
    end

    // Read muxes with write-first bypass and error detection
    always_comb begin
        readNext = '0;
        errNext  = 1'b0;
        if (stateQ == StIdle) begin
            errNext = WE && !wInRange;
            for (int unsigned r = 0; r < R; r++) begin
                if (!rInRange[r]) begin
                    errNext = 1'b1;
                end else if (writeOk && (addressWritePort == rAddr[r])) begin
                    readNext[r*N +: N] = writePortData;
                end else begin
                    readNext[r*N +: N] = mem[rAddr[r]];
                end
            end
        end
    end

    // Registered read data and error flag
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            readDatas <= '0;
            addrError <= 1'b0;
        end else begin
            readDatas <= readNext;
            addrError <= errNext;
        end
    end

endmodule

// File: tb/tb_ram_multiport_clr.sv
// Self-checking bench for ram_multiport_clr against a behavioural array model.
module tb_ram_multiport_clr;

    localparam int N = 16;
    localparam int M = 6000;
    localparam int K = 13;
    localparam int R = 4;

    logic           Clk = 1'b0;
    logic           RstN = 1'b1;
    logic           WE = 1'b0;
    logic [K-1:0]   wAddr = '0;
    logic [N-1:0]   wData = '0;
    logic [K-1:0]   rAddr [R];
    logic [R*K-1:0] readAddresses;
    logic [R*N-1:0] readDatas;
    logic           clearReq = 1'b0;
    logic           busy;
    logic           addrError;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [N-1:0] model [M];
    int           clearLeft;
    logic [N-1:0] expRead [R];
    logic         expErr;
    logic         expBusy;

    always #5 Clk = ~Clk;

    always_comb begin
        readAddresses = '0;
        for (int p = 0; p < R; p++) readAddresses[p*K +: K] = rAddr[p];
    end

    ram_multiport_clr #(.N(N), .M(M), .K(K), .R(R)) dut (
        .Clk              (Clk),
        .RstN             (RstN),
        .WE               (WE),
        .addressWritePort (wAddr),
        .writePortData    (wData),
        .readAddresses    (readAddresses),
        .readDatas        (readDatas),
        .clearReq         (clearReq),
        .busy             (busy),
        .addrError        (addrError)
    );

    function automatic logic [K-1:0] pickAddr();
        logic [31:0] v;
        if ($urandom_range(0, 7) == 0) v = $urandom_range(M, (1 << K) - 1);
        else                           v = $urandom_range(0, 15);
        return v[K-1:0];
    endfunction

    function automatic logic [N-1:0] port(input int p);
        return readDatas[p*N +: N];
    endfunction

    // Predict the outcome of the coming edge from the current inputs, then clock
    task automatic tick();
        if (clearLeft > 0) begin
            for (int p = 0; p < R; p++) expRead[p] = '0;
            expErr = 1'b0;
            clearLeft--;
        end else begin
            expErr = WE && (int'(wAddr) >= M);
            for (int p = 0; p < R; p++) begin
                if (int'(rAddr[p]) >= M) begin
                    expRead[p] = '0;
                    expErr     = 1'b1;
                end else if (WE && !clearReq && int'(wAddr) < M && wAddr == rAddr[p]) begin
                    expRead[p] = wData;
                end else begin
                    expRead[p] = model[rAddr[p]];
                end
            end
            if (clearReq) begin
                clearLeft = M;
                for (int a = 0; a < M; a++) model[a] = '0;
            end else if (WE && int'(wAddr) < M) begin
                model[wAddr] = wData;
            end
        end
        expBusy = (clearLeft > 0);
        @(posedge Clk);
        #1;
    endtask

    task automatic idleInputs();
        WE = 1'b0; clearReq = 1'b0; wAddr = '0; wData = '0;
        for (int p = 0; p < R; p++) rAddr[p] = '0;
    endtask

    task automatic assertReset();
        idleInputs();
        #2 RstN = 1'b0;
        #1;
    endtask

    task automatic releaseReset();
        @(posedge Clk);
        @(posedge Clk);
        #3 RstN = 1'b1;
        clearLeft = M;
        for (int a = 0; a < M; a++) model[a] = '0;
    endtask

    // Count edges until busy drops, bounded; a correct clear takes exactly M
    task automatic countClear(input string name);
        int cnt = 0;
        for (int i = 0; i < M + 20; i++) begin
            tick();
            cnt++;
            if (busy !== 1'b1) break;
        end
        checks++;
        if (cnt !== M) begin
            errors++;
            $display("FAIL %s clear length: got %0d edges, expected %0d", name, cnt, M);
        end
    endtask

    task automatic test_reset();
        assertReset();
        checks++;
        if (busy !== 1'b1 || readDatas !== '0 || addrError !== 1'b0) begin
            errors++;
            $display("FAIL reset state: busy=%b readDatas=%h addrError=%b, expected 1/0/0",
                     busy, readDatas, addrError);
        end
        releaseReset();
        countClear("reset");
        rAddr[0] = K'(M - 1);
        tick();
        checks++;
        if (port(0) !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset read 5999: got %h busy=%b, expected 0000 busy=0", port(0), busy);
        end
    endtask

    task automatic test_write_read();
        for (int j = 10; j < 20; j++) begin
            WE = 1'b1;
            wAddr = K'(j - 10);
            wData = N'(j);
            rAddr[0] = K'(j - 10);
            rAddr[1] = (j == 10) ? K'(0) : K'(j - 11);
            rAddr[2] = pickAddr() % 16;
            rAddr[3] = pickAddr() % 16;
            tick();
            checks++;
            if (port(0) !== N'(j)) begin
                errors++;
                $display("FAIL write_read bypass j=%0d: got %h expected %h", j, port(0), N'(j));
            end
            checks++;
            if (port(1) !== ((j == 10) ? N'(10) : N'(j - 1))) begin
                errors++;
                $display("FAIL write_read prev j=%0d: got %h expected %h", j, port(1),
                         (j == 10) ? N'(10) : N'(j - 1));
            end
        end
        idleInputs();
    endtask

    task automatic test_multiport();
        WE = 1'b1; wAddr = K'(100); wData = 16'hBEEF;
        tick();
        WE = 1'b0;
        for (int p = 0; p < R; p++) rAddr[p] = K'(100);
        tick();
        for (int p = 0; p < R; p++) begin
            checks++;
            if (port(p) !== 16'hBEEF) begin
                errors++;
                $display("FAIL multiport port%0d: got %h expected beef", p, port(p));
            end
        end
        WE = 1'b1; wData = 16'h1234;
        tick();
        for (int p = 0; p < R; p++) begin
            checks++;
            if (port(p) !== 16'h1234) begin
                errors++;
                $display("FAIL multiport bypass port%0d: got %h expected 1234", p, port(p));
            end
        end
        idleInputs();
    endtask

    task automatic test_range();
        WE = 1'b1; wAddr = K'(M); wData = 16'hAAAA;
        rAddr[0] = '0; rAddr[1] = K'(8191);
        tick();
        checks++;
        if (port(1) !== '0 || addrError !== 1'b1) begin
            errors++;
            $display("FAIL range error: port1=%h addrError=%b, expected 0000/1", port(1), addrError);
        end
        tick();
        checks++;
        if (addrError !== 1'b1) begin
            errors++;
            $display("FAIL range repeat: addrError=%b expected 1", addrError);
        end
        idleInputs();
        tick();
        checks++;
        if (addrError !== 1'b0 || port(0) !== 16'd10) begin
            errors++;
            $display("FAIL range after: addrError=%b addr0=%h, expected 0/000a", addrError, port(0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            WE = 1'($urandom_range(0, 1));
            wAddr = pickAddr();
            wData = N'($urandom);
            for (int p = 0; p < R; p++) rAddr[p] = pickAddr();
            tick();
            for (int p = 0; p < R; p++) begin
                checks++;
                if (port(p) !== expRead[p]) begin
                    errors++;
                    $display("FAIL random read c%0d port%0d: got %h expected %h",
                             i, p, port(p), expRead[p]);
                end
            end
            checks++;
            if (addrError !== expErr || busy !== expBusy) begin
                errors++;
                $display("FAIL random flags c%0d: addrError=%b busy=%b, expected %b/%b",
                         i, addrError, busy, expErr, expBusy);
            end
        end
        idleInputs();
    endtask

    task automatic test_clear_priority();
        int cnt = 0;
        WE = 1'b1; wAddr = K'(3); wData = N'(7);
        tick();
        wData = N'(9); clearReq = 1'b1; rAddr[0] = K'(3);
        tick();
        checks++;
        if (busy !== 1'b1 || port(0) !== N'(7)) begin
            errors++;
            $display("FAIL clear priority: busy=%b addr3=%h, expected 1/0007", busy, port(0));
        end
        for (int i = 0; i < M + 20; i++) begin
            WE = 1'b1; wAddr = K'(3); wData = N'(9);
            clearReq = 1'($urandom_range(0, 1));
            rAddr[1] = K'(8191);
            tick();
            cnt++;
            if (busy !== 1'b1) break;
            if (readDatas !== '0 || addrError !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL clear outputs edge %0d: readDatas=%h addrError=%b", cnt,
                         readDatas, addrError);
            end
        end
        checks++;
        if (cnt !== M) begin
            errors++;
            $display("FAIL clear priority length: got %0d edges, expected %0d", cnt, M);
        end
        idleInputs();
        rAddr[0] = K'(3);
        tick();
        checks++;
        if (port(0) !== '0) begin
            errors++;
            $display("FAIL clear priority addr3: got %h expected 0000", port(0));
        end
    endtask

    task automatic test_mid_clear_reset();
        WE = 1'b1; wAddr = K'(50); wData = 16'h5A5A;
        tick();
        WE = 1'b0; rAddr[0] = K'(50); rAddr[1] = K'(8000);
        tick();
        checks++;
        if (port(0) !== 16'h5A5A || addrError !== 1'b1) begin
            errors++;
            $display("FAIL pre-reset read: got %h addrError=%b, expected 5a5a/1", port(0), addrError);
        end
        assertReset();
        checks++;
        if (readDatas !== '0 || addrError !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL idle reset async: readDatas=%h addrError=%b busy=%b", readDatas,
                     addrError, busy);
        end
        releaseReset();
        for (int i = 0; i < 2000; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid-clear busy at 2000: got %b expected 1", busy);
        end
        assertReset();
        checks++;
        if (readDatas !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid-clear reset: readDatas=%h busy=%b, expected 0/1", readDatas, busy);
        end
        releaseReset();
        countClear("mid-clear reset");
        rAddr[0] = K'(50);
        tick();
        checks++;
        if (port(0) !== '0) begin
            errors++;
            $display("FAIL mid-clear addr50: got %h expected 0000", port(0));
        end
    endtask

    initial begin
        clearLeft = M;
        idleInputs();
        test_reset();
        test_write_read();
        test_multiport();
        test_range();
        test_random();
        test_clear_priority();
        test_mid_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
